// File: rtl/mem_defs_pkg.sv
// Shared memory-bus types: store sizes, arbiter states and the captured request bundle.
// Kept separate so future multi-master buses can reuse the same request record.
package mem_defs;

  localparam int DBUS_XLEN = 32;

  typedef enum logic [1:0] {
    ST_SB = 2'd0,
    ST_SH = 2'd1,
    ST_SW = 2'd2
  } type_st_ops_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } type_dbus_arb_state_e;

  typedef struct packed {
    logic                 ld_req;
    logic                 st_req;
    logic [DBUS_XLEN-1:0] addr;
    logic [DBUS_XLEN-1:0] w_data;
    type_st_ops_e         st_ops;
  } type_dbus_req_s;

endpackage

// File: rtl/dbus_arbiter_if.sv
// Two-requester data-bus bundle: M0/M1 request/response sides plus the shared slave port.
interface dbus_arbiter_if #(
  parameter int XLEN = 32
);
  import mem_defs::*;

  logic              m0_ld_req;
  logic              m0_st_req;
  logic [XLEN-1:0]   m0_addr;
  logic [XLEN-1:0]   m0_w_data;
  type_st_ops_e      m0_st_ops;
  logic              m0_flush;
  logic              m0_ack;
  logic              m0_err;
  logic [XLEN-1:0]   m0_r_data;

  logic              m1_ld_req;
  logic              m1_st_req;
  logic [XLEN-1:0]   m1_addr;
  logic [XLEN-1:0]   m1_w_data;
  type_st_ops_e      m1_st_ops;
  logic              m1_ack;
  logic              m1_err;
  logic [XLEN-1:0]   m1_r_data;

  logic              s_ld_req;
  logic              s_st_req;
  logic [XLEN-1:0]   s_addr;
  logic [XLEN-1:0]   s_w_data;
  type_st_ops_e      s_st_ops;
  logic              s_ack;
  logic [XLEN-1:0]   s_r_data;

  modport arb (
    input  m0_ld_req, m0_st_req, m0_addr, m0_w_data, m0_st_ops, m0_flush,
    output m0_ack, m0_err, m0_r_data,
    input  m1_ld_req, m1_st_req, m1_addr, m1_w_data, m1_st_ops,
    output m1_ack, m1_err, m1_r_data,
    output s_ld_req, s_st_req, s_addr, s_w_data, s_st_ops,
    input  s_ack, s_r_data
  );

  modport master (
    output m0_ld_req, m0_st_req, m0_addr, m0_w_data, m0_st_ops, m0_flush,
    input  m0_ack, m0_err, m0_r_data,
    output m1_ld_req, m1_st_req, m1_addr, m1_w_data, m1_st_ops,
    input  m1_ack, m1_err, m1_r_data
  );

  modport slave (
    input  s_ld_req, s_st_req, s_addr, s_w_data, s_st_ops,
    output s_ack, s_r_data
  );

endinterface

// File: rtl/dbus_arbiter_rr_arbiter2.sv
// Two-input round-robin pick: on a tie the master that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid,
  output logic       gnt
);

  assign valid = |req;
  assign gnt   = (req == 2'b11) ? ~last_gnt : req[1];

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data-bus slave between the core LSU (M0) and an auxiliary master (M1),
// one transaction at a time, with a per-transaction timeout and an M0 flush drain.
module dbus_arbiter
  import mem_defs::*;
#(
  parameter int XLEN    = DBUS_XLEN,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  dbus_arbiter_if.arb bus
);

  type_dbus_arb_state_e state;
  type_dbus_req_s       s_req;
  type_dbus_req_s       pick;
  logic                 owner;
  logic                 last_gnt;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           req;
  logic                 gnt_valid;
  logic                 gnt;
  logic                 timeout;
  logic                 done_ack;
  logic                 done_err;

  // A flushing M0 must not win a fresh grant.
  assign req[0] = (bus.m0_ld_req | bus.m0_st_req) & ~bus.m0_flush;
  assign req[1] = bus.m1_ld_req | bus.m1_st_req;

  rr_arbiter2 u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .valid    (gnt_valid),
    .gnt      (gnt)
  );

  always_comb begin
    pick = '0;
    if (gnt) begin
      pick.ld_req = bus.m1_ld_req;
      pick.st_req = bus.m1_st_req & ~bus.m1_ld_req;
      pick.addr   = bus.m1_addr;
      pick.w_data = bus.m1_w_data;
      pick.st_ops = bus.m1_st_ops;
    end else begin
      pick.ld_req = bus.m0_ld_req;
      pick.st_req = bus.m0_st_req & ~bus.m0_ld_req;
      pick.addr   = bus.m0_addr;
      pick.w_data = bus.m0_w_data;
      pick.st_ops = bus.m0_st_ops;
    end
  end

  assign timeout  = (cnt == CNT_W'(TIMEOUT - 1));
  // Responses only surface from BUSY; in DRAIN both ack and timeout are swallowed.
  assign done_ack = (state == BUSY) & bus.s_ack;
  assign done_err = (state == BUSY) & ~bus.s_ack & timeout;

  assign bus.m0_ack    = done_ack & ~owner;
  assign bus.m1_ack    = done_ack &  owner;
  assign bus.m0_err    = done_err & ~owner;
  assign bus.m1_err    = done_err &  owner;
  assign bus.m0_r_data = bus.m0_ack ? bus.s_r_data : {XLEN{1'b0}};
  assign bus.m1_r_data = bus.m1_ack ? bus.s_r_data : {XLEN{1'b0}};

  assign bus.s_ld_req = s_req.ld_req;
  assign bus.s_st_req = s_req.st_req;
  assign bus.s_addr   = s_req.addr;
  assign bus.s_w_data = s_req.w_data;
  assign bus.s_st_ops = s_req.st_ops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      cnt      <= '0;
      s_req    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            s_req    <= pick;
            owner    <= gnt;
            last_gnt <= gnt;
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY, DRAIN: begin
          if (bus.s_ack || timeout) begin
            s_req.ld_req <= 1'b0;
            s_req.st_req <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (state == BUSY && !owner && bus.m0_flush) begin
              state <= DRAIN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus randomized transactions scored
// against a transaction-level round-robin / timeout model.
module tb_dbus_arbiter;
  import mem_defs::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   model_last;

  // Random-test request state per master
  logic            p   [2];
  logic            ld  [2];
  logic            st  [2];
  logic [XLEN-1:0] addr[2];
  logic [XLEN-1:0] wd  [2];
  type_st_ops_e    ops [2];

  always #5 clk = ~clk;

  dbus_arbiter_if #(.XLEN(XLEN)) bus ();

  dbus_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m0_ld_req = 1'b0; bus.m0_st_req = 1'b0; bus.m0_addr = '0; bus.m0_w_data = '0;
    bus.m0_st_ops = ST_SB; bus.m0_flush = 1'b0;
    bus.m1_ld_req = 1'b0; bus.m1_st_req = 1'b0; bus.m1_addr = '0; bus.m1_w_data = '0;
    bus.m1_st_ops = ST_SB;
    bus.s_ack = 1'b0; bus.s_r_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = 1;
  endtask

  task automatic drive_all();
    bus.m0_ld_req = p[0] & ld[0]; bus.m0_st_req = p[0] & st[0];
    bus.m0_addr = addr[0]; bus.m0_w_data = wd[0]; bus.m0_st_ops = ops[0];
    bus.m1_ld_req = p[1] & ld[1]; bus.m1_st_req = p[1] & st[1];
    bus.m1_addr = addr[1]; bus.m1_w_data = wd[1]; bus.m1_st_ops = ops[1];
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    checks++;
    if ({bus.s_ld_req, bus.s_st_req, bus.s_addr, bus.s_w_data, bus.s_st_ops} !== '0) begin
      errors++;
      $display("FAIL reset_slave: got ld=%0b st=%0b addr=%h wd=%h ops=%0d, expected all 0",
               bus.s_ld_req, bus.s_st_req, bus.s_addr, bus.s_w_data, bus.s_st_ops);
    end
    checks++;
    if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 4'b0 ||
        bus.m0_r_data !== '0 || bus.m1_r_data !== '0) begin
      errors++;
      $display("FAIL reset_master: got ack=%b%b err=%b%b rd0=%h rd1=%h, expected all 0",
               bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err, bus.m0_r_data, bus.m1_r_data);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_load();
    cyc();
    bus.m0_ld_req = 1'b1; bus.m0_addr = 32'h100;
    smp();
    checks++;
    if (bus.s_ld_req !== 1'b0) begin
      errors++; $display("FAIL load_latency: s_ld_req=%b in request cycle, expected 0", bus.s_ld_req);
    end
    cyc(); smp();
    checks++;
    if (bus.s_ld_req !== 1'b1 || bus.s_addr !== 32'h100 || bus.m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL load_grant: s_ld_req=%b s_addr=%h m0_ack=%b, expected 1 00000100 0",
               bus.s_ld_req, bus.s_addr, bus.m0_ack);
    end
    repeat (2) begin cyc(); smp(); end
    cyc();
    bus.s_ack = 1'b1; bus.s_r_data = 32'hDEADBEEF;
    smp();
    checks++;
    if (bus.m0_ack !== 1'b1 || bus.m0_r_data !== 32'hDEADBEEF || bus.m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL load_ack: m0_ack=%b m0_r_data=%h m1_ack=%b, expected 1 deadbeef 0",
               bus.m0_ack, bus.m0_r_data, bus.m1_ack);
    end
    cyc();
    bus.s_ack = 1'b0; bus.m0_ld_req = 1'b0;
    smp();
    checks++;
    if (bus.m0_ack !== 1'b0 || bus.s_ld_req !== 1'b0) begin
      errors++;
      $display("FAIL load_after: m0_ack=%b s_ld_req=%b, expected 0 0", bus.m0_ack, bus.s_ld_req);
    end
    $display("test_single_load done");
  endtask

  task automatic test_round_robin();
    int exp_w;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      bus.m0_ld_req = 1'b1; bus.m0_addr = 32'h1000 + g;
      bus.m1_ld_req = 1'b1; bus.m1_addr = 32'h2000 + g;
      exp_w = g % 2;
      smp();
      cyc(); smp();
      checks++;
      if (bus.s_addr !== ((exp_w == 1) ? 32'h2000 + g : 32'h1000 + g)) begin
        errors++;
        $display("FAIL rr_grant %0d: s_addr=%h, expected grant to M%0d", g, bus.s_addr, exp_w);
      end
      cyc();
      bus.s_ack = 1'b1; bus.s_r_data = 32'hA0 + g;
      smp();
      checks++;
      if ({bus.m1_ack, bus.m0_ack} !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_ack %0d: m1_ack,m0_ack=%b%b, expected only M%0d", g, bus.m1_ack, bus.m0_ack, exp_w);
      end
      $display("rr grant %0d -> M%0d", g, exp_w);
      cyc();
      bus.s_ack = 1'b0;
    end
    bus.m0_ld_req = 1'b0; bus.m1_ld_req = 1'b0;
    model_last = 1;
    smp();
  endtask

  task automatic test_hold();
    cyc();
    bus.m1_st_req = 1'b1; bus.m1_addr = 32'h20; bus.m1_w_data = 32'h55; bus.m1_st_ops = ST_SW;
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.m0_addr = $urandom; bus.m0_w_data = $urandom;
      if (k == 4) begin bus.s_ack = 1'b1; bus.s_r_data = 32'h0; end
      smp();
      checks++;
      if (bus.s_st_req !== 1'b1 || bus.s_ld_req !== 1'b0 || bus.s_addr !== 32'h20 ||
          bus.s_w_data !== 32'h55 || bus.s_st_ops !== ST_SW) begin
        errors++;
        $display("FAIL hold %0d: st=%b ld=%b addr=%h wd=%h ops=%0d, expected 1 0 20 55 %0d",
                 k, bus.s_st_req, bus.s_ld_req, bus.s_addr, bus.s_w_data, bus.s_st_ops, ST_SW);
      end
    end
    checks++;
    if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0) begin
      errors++; $display("FAIL hold_ack: m1_ack=%b m0_ack=%b, expected 1 0", bus.m1_ack, bus.m0_ack);
    end
    cyc();
    bus.s_ack = 1'b0; bus.m1_st_req = 1'b0; bus.m0_addr = '0; bus.m0_w_data = '0;
    smp();
    checks++;
    if (bus.s_st_req !== 1'b0 || bus.m1_ack !== 1'b0) begin
      errors++; $display("FAIL hold_after: s_st_req=%b m1_ack=%b, expected 0 0", bus.s_st_req, bus.m1_ack);
    end
    model_last = 1;
    $display("test_hold done");
  endtask

  task automatic test_timeout();
    int n_high = 0;
    int err_at = -1;
    cyc();
    bus.m1_ld_req = 1'b1; bus.m1_addr = 32'h44;
    for (int k = 0; k < 30 && err_at < 0; k++) begin
      cyc(); smp();
      if (bus.s_ld_req === 1'b1) n_high++;
      if (bus.m1_err === 1'b1) err_at = n_high;
    end
    checks++;
    if (err_at != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_err: err seen on slave-req cycle %0d (-1 = never), expected %0d", err_at, TIMEOUT);
    end
    cyc();
    bus.m1_ld_req = 1'b0; bus.m0_ld_req = 1'b1; bus.m0_addr = 32'h88;
    smp();
    checks++;
    if (bus.s_ld_req !== 1'b0 || bus.m1_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: s_ld_req=%b m1_err=%b, expected 0 0", bus.s_ld_req, bus.m1_err);
    end
    cyc(); smp();
    checks++;
    if (bus.s_ld_req !== 1'b1 || bus.s_addr !== 32'h88) begin
      errors++;
      $display("FAIL timeout_regrant: s_ld_req=%b s_addr=%h, expected 1 00000088", bus.s_ld_req, bus.s_addr);
    end
    cyc();
    bus.s_ack = 1'b1;
    smp();
    cyc();
    bus.s_ack = 1'b0; bus.m0_ld_req = 1'b0;
    smp();
    model_last = 0;
    $display("test_timeout done");
  endtask

  task automatic test_flush();
    logic saw_ack = 1'b0;
    cyc();
    bus.m0_ld_req = 1'b1; bus.m0_addr = 32'h300;
    cyc(); smp();
    cyc(); smp();
    cyc();
    bus.m0_flush = 1'b1; bus.m0_ld_req = 1'b0;
    smp();
    if (bus.m0_ack === 1'b1) saw_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.m0_flush = 1'b0;
      if (k == 2) begin bus.s_ack = 1'b1; bus.s_r_data = 32'hCAFE; end
      smp();
      if (bus.m0_ack === 1'b1) saw_ack = 1'b1;
      checks++;
      if (bus.s_ld_req !== 1'b1 || bus.m0_r_data !== '0) begin
        errors++;
        $display("FAIL drain_hold %0d: s_ld_req=%b m0_r_data=%h, expected 1 0", k, bus.s_ld_req, bus.m0_r_data);
      end
    end
    checks++;
    if (saw_ack !== 1'b0) begin
      errors++; $display("FAIL drain_ack: m0_ack pulsed during drain, expected none");
    end
    cyc();
    bus.s_ack = 1'b0;
    smp();
    checks++;
    if (bus.s_ld_req !== 1'b0) begin
      errors++; $display("FAIL drain_end: s_ld_req=%b, expected 0", bus.s_ld_req);
    end
    cyc();
    bus.m0_ld_req = 1'b1; bus.m0_addr = 32'h304;
    cyc(); smp();
    cyc();
    bus.m0_flush = 1'b1; bus.s_ack = 1'b1; bus.s_r_data = 32'h1234;
    smp();
    checks++;
    if (bus.m0_ack !== 1'b1 || bus.m0_r_data !== 32'h1234) begin
      errors++;
      $display("FAIL flush_with_ack: m0_ack=%b m0_r_data=%h, expected 1 00001234", bus.m0_ack, bus.m0_r_data);
    end
    cyc();
    bus.m0_flush = 1'b0; bus.s_ack = 1'b0; bus.m0_ld_req = 1'b0;
    smp();
    model_last = 0;
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    cyc();
    bus.m0_ld_req = 1'b1; bus.m0_addr = 32'h500; bus.m0_w_data = 32'h77;
    cyc(); smp();
    bus.s_ack = 1'b1; bus.s_r_data = 32'hBEEF;
    #1;
    checks++;
    if (bus.m0_ack !== 1'b1) begin
      errors++; $display("FAIL arst_pre: m0_ack=%b, expected 1", bus.m0_ack);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.s_ld_req, bus.s_st_req, bus.s_addr, bus.s_w_data, bus.s_st_ops,
         bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.m0_r_data, bus.m1_r_data} !== '0) begin
      errors++;
      $display("FAIL arst_outputs: s_ld=%b s_addr=%h m0_ack=%b m0_r_data=%h, expected all 0",
               bus.s_ld_req, bus.s_addr, bus.m0_ack, bus.m0_r_data);
    end
    clear_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    bus.m0_ld_req = 1'b1; bus.m0_addr = 32'h600;
    bus.m1_ld_req = 1'b1; bus.m1_addr = 32'h700;
    cyc(); smp();
    checks++;
    if (bus.s_addr !== 32'h600) begin
      errors++; $display("FAIL arst_tie: s_addr=%h, expected 00000600 (M0)", bus.s_addr);
    end
    cyc();
    bus.s_ack = 1'b1;
    smp();
    cyc();
    clear_inputs();
    smp();
    model_last = 0;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int w, d, j;
    logic done;
    logic exp_ack, exp_err;
    logic [XLEN-1:0] rd;
    logic [3:0] exp_v;
    do_reset();
    for (int k = 0; k < 2; k++) p[k] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p[k] && $urandom_range(0, 2) != 0) begin
          p[k] = 1'b1;
          ld[k] = 1'($urandom_range(0, 1));
          st[k] = ld[k] ? 1'($urandom_range(0, 1)) : 1'b1;
          addr[k] = $urandom; wd[k] = $urandom;
          ops[k] = type_st_ops_e'(2'($urandom_range(0, 2)));
        end
      end
      if (!p[0] && !p[1]) begin
        w = int'($urandom_range(0, 1));
        p[w] = 1'b1; ld[w] = 1'b1; st[w] = 1'b0; addr[w] = $urandom; wd[w] = $urandom; ops[w] = ST_SW;
      end
      drive_all();
      w = (p[0] && p[1]) ? 1 - model_last : (p[0] ? 0 : 1);
      model_last = w;
      d = int'($urandom_range(0, TIMEOUT + 1));
      smp();
      checks++;
      if (bus.s_ld_req !== 1'b0 || bus.s_st_req !== 1'b0) begin
        errors++; $display("FAIL rnd_idle txn %0d: s_ld=%b s_st=%b, expected 0 0", t, bus.s_ld_req, bus.s_st_req);
      end
      j = 0;
      done = 1'b0;
      while (!done) begin
        cyc();
        bus.s_ack = (j == d);
        bus.s_r_data = $urandom;
        rd = bus.s_r_data;
        for (int k = 0; k < 2; k++) if (!p[k]) addr[k] = $urandom;
        drive_all();
        smp();
        exp_ack = (j == d) && (d < TIMEOUT);
        exp_err = (d >= TIMEOUT) && (j == TIMEOUT - 1);
        exp_v = {exp_err & (w == 1), exp_err & (w == 0), exp_ack & (w == 1), exp_ack & (w == 0)};
        checks++;
        if (bus.s_ld_req !== ld[w] || bus.s_st_req !== (st[w] & ~ld[w]) || bus.s_addr !== addr[w] ||
            bus.s_w_data !== wd[w] || bus.s_st_ops !== ops[w]) begin
          errors++;
          $display("FAIL rnd_fields txn %0d cyc %0d: ld=%b st=%b addr=%h wd=%h ops=%0d, expected M%0d %b %b %h %h %0d",
                   t, j, bus.s_ld_req, bus.s_st_req, bus.s_addr, bus.s_w_data, bus.s_st_ops,
                   w, ld[w], st[w] & ~ld[w], addr[w], wd[w], ops[w]);
        end
        checks++;
        if ({bus.m1_err, bus.m0_err, bus.m1_ack, bus.m0_ack} !== exp_v ||
            bus.m0_r_data !== ((exp_ack && w == 0) ? rd : '0) ||
            bus.m1_r_data !== ((exp_ack && w == 1) ? rd : '0)) begin
          errors++;
          $display("FAIL rnd_resp txn %0d cyc %0d: err1,err0,ack1,ack0=%b rd0=%h rd1=%h, expected %b (rdata %h to M%0d)",
                   t, j, {bus.m1_err, bus.m0_err, bus.m1_ack, bus.m0_ack}, bus.m0_r_data, bus.m1_r_data,
                   exp_v, rd, w);
        end
        if (exp_ack || exp_err || j > TIMEOUT + 4) done = 1'b1;
        j++;
      end
      $display("rnd txn %0d: M%0d %s delay %0d -> %s", t, w, ld[w] ? "ld" : "st", d,
               (d < TIMEOUT) ? "ack" : "err");
      cyc();
      bus.s_ack = 1'b0;
      p[w] = 1'b0;
      drive_all();
    end
    for (int k = 0; k < 2; k++) p[k] = 1'b0;
    drive_all();
    smp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_load();
    test_round_robin();
    test_hold();
    test_timeout();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
